// File: rtl/synchronizer_level.sv
// synchronizer_level
// Multi-bit level synchronizer into the clk_out domain. Each bit runs through
// its own STAGES-deep flop chain. A history flop after the last stage lets the
// block flag the first enabled cycle in which a bit is seen high.
// STAGES is expected to be in the range 2..4.
// All bits are independent; a multi-bit word is not guaranteed to arrive
// coherently in a single cycle.

module synchronizer_level #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_out_reg2,
    output logic [WIDTH-1:0] sync_out_p1
);

    // stage_q[0] is the capture flop and stage_q[STAGES-1] is the output stage.
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    // Next state: shift the chain on enabled edges and hold it otherwise.
    // sync_in reaches the first stage through the enable mux only.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        hist_d = hist_q;
        if (clk_en) begin
            stage_d[0] = sync_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            hist_d = stage_q[STAGES-1];
        end
    end

    // Register the chain. Reset clears every flop, whatever clk_en is, and the
    // cleared value counts as "low" for edge detection afterwards.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            hist_q <= hist_d;
        end
    end

    // The level output comes straight from the last flop. The pulse output is
    // gated by clk_en, so it stays low in disabled cycles and lasts exactly one
    // enabled cycle.
    assign sync_out_reg2 = stage_q[STAGES-1];
    assign sync_out_p1   = stage_q[STAGES-1] & ~hist_q & {WIDTH{clk_en}};

endmodule

// File: tb/tb_synchronizer_level.sv
// Bench for synchronizer_level (WIDTH=4, STAGES=2). A queue-based model checks
// the outputs on every cycle. Directed scenarios pin the model with literal
// values, and a randomized phase follows them.

module tb_synchronizer_level;

  localparam int W = 4;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_en = 1'b1;
  logic [W-1:0] sync_in = '0;
  logic [W-1:0] sync_out_reg2;
  logic [W-1:0] sync_out_p1;

  always #5 clk = ~clk;

  synchronizer_level #(.WIDTH(W), .STAGES(S)) dut (
    .clk_out      (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .sync_in      (sync_in),
    .sync_out_reg2(sync_out_reg2),
    .sync_out_p1  (sync_out_p1)
  );

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int pulse_cnt [W];

  // ---------------- reference model ----------------
  // exp_q[n] is the input word sampled n enabled edges ago, counted since the
  // last reset. Reset fills the history with zeros. The synchronized level is
  // the sample taken S-1 enabled edges back. A pulse occurs where that sample
  // is high and the sample one enabled edge older is low.
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      exp_q = {};
      for (int i = 0; i <= S; i++) exp_q.push_back('0);
    end else if (clk_en) begin
      exp_q.push_front(sync_in);
      void'(exp_q.pop_back());
    end
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] e_lvl;
    logic [W-1:0] e_p1;
    if (chk_on) begin
      e_lvl = exp_q[S-1];
      e_p1  = exp_q[S-1] & ~exp_q[S] & {W{clk_en}};
      total++;
      if (sync_out_reg2 !== e_lvl) begin
        bad++;
        $display("FAIL model_reg2 t=%0t: got %b want %b", $time, sync_out_reg2, e_lvl);
      end
      total++;
      if (sync_out_p1 !== e_p1) begin
        bad++;
        $display("FAIL model_p1 t=%0t: got %b want %b", $time, sync_out_p1, e_p1);
      end
      for (int b = 0; b < W; b++) pulse_cnt[b] += int'(sync_out_p1[b]);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_cnt();
    for (int b = 0; b < W; b++) pulse_cnt[b] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_cnt();

    // Reset state.
    tick(1);
    chk_on = 1'b1;
    tick(1);
    check("reset_reg2", sync_out_reg2, 4'b0000);
    check("reset_p1", sync_out_p1, 4'b0000);
    rst = 1'b0;
    tick(2);

    // Basic two-stage latency: the rise is sampled at edge k and shows up
    // after edge k+1.
    clear_cnt();
    sync_in = 4'b0001;
    tick(1);
    check("lat_k_reg2", sync_out_reg2, 4'b0000);
    check("lat_k_p1", sync_out_p1, 4'b0000);
    tick(1);
    check("lat_k1_reg2", sync_out_reg2, 4'b0001);
    check("lat_k1_p1", sync_out_p1, 4'b0001);
    tick(1);
    check("lat_k2_p1", sync_out_p1, 4'b0000);

    // Long high, then a fall: one pulse, two-edge fall latency, and no pulse
    // on the fall.
    tick(7);
    sync_in = 4'b0000;
    tick(1);
    check("fall_m_reg2", sync_out_reg2, 4'b0001);
    tick(1);
    check("fall_m1_reg2", sync_out_reg2, 4'b0000);
    check("fall_m1_p1", sync_out_p1, 4'b0000);
    tick(3);
    check_int("long_high_pulses", pulse_cnt[0], 1);

    // clk_en alternating while the input rises.
    clear_cnt();
    for (int i = 0; i < 8; i++) begin
      clk_en  = (i % 2 == 0);
      sync_in = 4'b0001;
      #1;
      if (i == 1) check("en_hold_reg2", sync_out_reg2, 4'b0000);
      if (i == 3) check("en_off_p1", sync_out_p1, 4'b0000);
      if (i == 4) check("en_on_p1", sync_out_p1, 4'b0001);
      tick(1);
    end
    check_int("en_toggle_pulses", pulse_cnt[0], 1);
    check("en_toggle_reg2", sync_out_reg2, 4'b0001);
    clk_en = 1'b1;

    // Reset held with the input high, then released.
    rst = 1'b1;
    tick(1);
    check("rst_hold_reg2", sync_out_reg2, 4'b0000);
    check("rst_hold_p1", sync_out_p1, 4'b0000);
    tick(2);
    rst = 1'b0;
    clear_cnt();
    tick(1);
    check("rst_rel1_reg2", sync_out_reg2, 4'b0000);
    tick(1);
    check("rst_rel2_reg2", sync_out_reg2, 4'b0001);
    check("rst_rel2_p1", sync_out_p1, 4'b0001);
    tick(3);
    check_int("rst_rel_pulses", pulse_cnt[0], 1);

    // Reset arrives mid-flight with the input already low again.
    sync_in = 4'b0000;
    tick(4);
    sync_in = 4'b0001;
    tick(1);
    rst = 1'b1;
    sync_in = 4'b0000;
    tick(1);
    rst = 1'b0;
    clear_cnt();
    tick(4);
    check("abort_reg2", sync_out_reg2, 4'b0000);
    check_int("abort_pulses", pulse_cnt[0], 0);

    // Multi-bit input.
    sync_in = 4'b0101;
    tick(1);
    check("wide_a_reg2", sync_out_reg2, 4'b0000);
    tick(1);
    check("wide_b_reg2", sync_out_reg2, 4'b0101);
    check("wide_b_p1", sync_out_p1, 4'b0101);
    sync_in = 4'b1111;
    tick(1);
    check("wide_c_p1", sync_out_p1, 4'b0000);
    tick(1);
    check("wide_d_p1", sync_out_p1, 4'b1010);
    check("wide_d_reg2", sync_out_reg2, 4'b1111);
    tick(1);
    check("wide_e_p1", sync_out_p1, 4'b0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sync_in = W'($urandom_range(0, (1 << W) - 1));
      clk_en  = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    rst = 1'b0;
    clk_en = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
